// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU result FIFO.
// Optional sticky flags are enabled with ALU_STICKY_FLAGS_EN.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_DEPTH = 4;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/alu_fifo_mem.sv
// Register-array storage for the ALU result FIFO.
// One write port, one asynchronous read port, no reset.
module alu_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH+2:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH+2:0] rdata
);

  logic [WIDTH+2:0] mem [DEPTH];

  // write the accepted entry into its slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// FIFO buffering ALU result words with their flags.
// Define ALU_STICKY_FLAGS_EN for sticky carry/overflow.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic                     sticky_clr,
  output logic                     sticky_carry,
  output logic                     sticky_ovf,
`endif
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  occ_e             occ_q;
  occ_e             occ_d;
  logic             push;
  logic             pop;
  alu_flags_t       wflags;
  alu_flags_t       rflags;
  logic [WIDTH+2:0] wdata;
  logic [WIDTH+2:0] rdata;

  assign full      = (occ_q == OCC_FULL);
  assign empty     = (occ_q == OCC_EMPTY);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt_q;

  assign wflags = '{
    carry:    in_carry,
    zero:     in_zero,
    overflow: in_overflow
  };
  assign wdata  = {in_result, wflags};

  alu_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign out_result   = rdata[WIDTH+2:3];
  assign rflags       = rdata[2:0];
  assign out_carry    = rflags.carry;
  assign out_zero     = rflags.zero;
  assign out_overflow = rflags.overflow;

  // next occupancy count; push+pop cancels
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // occupancy state follows the next count
  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      (cnt_d == '0):         occ_d = OCC_EMPTY;
      (cnt_d == CW'(DEPTH)): occ_d = OCC_FULL;
      default:               occ_d = OCC_PARTIAL;
    endcase
  end

  // pointers, count and occupancy state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  // clear wins over hold, then pushed flags OR in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
    end else begin
      sticky_carry <= (sticky_carry & !sticky_clr)
                    | (push & in_carry);
      sticky_ovf   <= (sticky_ovf & !sticky_clr)
                    | (push & in_overflow);
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo.
// Covers sticky flags when ALU_STICKY_FLAGS_EN is defined.
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;
  localparam int D = ALU_DEPTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_result;
  logic             in_carry;
  logic             in_zero;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_overflow;
  logic [$clog2(D):0] count;
  logic             full;
  logic             empty;
`ifdef ALU_STICKY_FLAGS_EN
  logic             sticky_clr;
  logic             sticky_carry;
  logic             sticky_ovf;
`endif

  alu_result_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .count        (count),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr   (sticky_clr),
    .sticky_carry (sticky_carry),
    .sticky_ovf   (sticky_ovf),
`endif
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
    logic         rdy;
    int           exp_cnt;
  } vec_t;

  int n_chk;
  int n_err;
  int m_cnt;
  logic [W+2:0] sbq [$];
  vec_t tbl [27];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [W+2:0] head;
    logic do_push;
    logic do_pop;
    in_valid    = v.valid;
    in_result   = v.res;
    in_carry    = v.c;
    in_zero     = v.z;
    in_overflow = v.o;
    out_ready   = v.rdy;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
    chk("in_ready", 32'(in_ready), 32'(m_cnt != D));
    chk("full", 32'(full), 32'(m_cnt == D));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    do_pop  = v.rdy && (m_cnt != 0);
    do_push = v.valid && (m_cnt != D);
    if (m_cnt != 0) begin
      head = {out_result, out_carry,
              out_zero, out_overflow};
      chk("head", 32'(head), 32'(sbq[0]));
    end
    if (do_pop) void'(sbq.pop_front());
    if (do_push) sbq.push_back({v.res, v.c, v.z, v.o});
    m_cnt = m_cnt + int'(do_push) - int'(do_pop);
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(v.exp_cnt));
  endtask

  initial begin
    vec_t v;
    n_chk = 0;
    n_err = 0;
    m_cnt = 0;
    // valid, res, c, z, o, rdy, count after edge
    tbl[0]  = '{1, 8'h80, 0, 0, 1, 0, 1};
    tbl[1]  = '{1, 8'h00, 1, 1, 0, 0, 2};
    tbl[2]  = '{1, 8'h05, 0, 0, 0, 0, 3};
    tbl[3]  = '{1, 8'h06, 0, 0, 0, 0, 4};
    tbl[4]  = '{1, 8'h09, 0, 0, 0, 1, 3};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 2};
    tbl[6]  = '{1, 8'h11, 0, 0, 0, 1, 2};
    tbl[7]  = '{1, 8'h21, 0, 0, 1, 0, 3};
    tbl[8]  = '{1, 8'h22, 1, 0, 0, 1, 3};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 1, 2};
    tbl[10] = '{1, 8'h23, 0, 1, 0, 0, 3};
    tbl[11] = '{1, 8'h24, 1, 0, 1, 0, 4};
    tbl[12] = '{1, 8'h25, 0, 0, 0, 0, 4};
    tbl[13] = '{0, 8'h00, 0, 0, 0, 1, 3};
    tbl[14] = '{1, 8'h26, 0, 0, 1, 1, 3};
    tbl[15] = '{0, 8'h00, 0, 0, 0, 1, 2};
    tbl[16] = '{1, 8'h27, 1, 0, 0, 1, 2};
    tbl[17] = '{0, 8'h00, 0, 0, 0, 1, 1};
    tbl[18] = '{0, 8'h00, 0, 0, 0, 1, 0};
    tbl[19] = '{0, 8'h00, 0, 0, 0, 1, 0};
    tbl[20] = '{0, 8'h00, 0, 0, 0, 1, 0};
    tbl[21] = '{0, 8'h00, 0, 0, 0, 1, 0};
    tbl[22] = '{1, 8'h33, 0, 0, 0, 0, 1};
    tbl[23] = '{1, 8'h34, 1, 0, 0, 0, 2};
    tbl[24] = '{1, 8'h35, 0, 0, 1, 0, 3};
    tbl[25] = '{1, 8'h44, 0, 0, 1, 0, 1};
    tbl[26] = '{0, 8'h00, 0, 0, 0, 1, 0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_result   = '0;
    in_carry    = 1'b0;
    in_zero     = 1'b0;
    in_overflow = 1'b0;
    out_ready   = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rst_sticky_c", 32'(sticky_carry), 32'd0);
    chk("rst_sticky_o", 32'(sticky_ovf), 32'd0);
`endif

    for (int i = 0; i < 4; i++) run(tbl[i]);
    @(negedge clk);
    chk("full_after4", 32'(full), 32'd1);
    chk("in_ready_full", 32'(in_ready), 32'd0);
    chk("head_res", 32'(out_result), 32'h80);
    chk("head_ovf", 32'(out_overflow), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 4; i < 25; i++) run(tbl[i]);

    // reset at count=3 wins over a concurrent push/pop
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_result = 8'h55;
    in_carry  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rst2_sticky_c", 32'(sticky_carry), 32'd0);
    chk("rst2_sticky_o", 32'(sticky_ovf), 32'd0);
`endif
    sbq.delete();
    m_cnt = 0;

    for (int i = 25; i < 27; i++) run(tbl[i]);

`ifdef ALU_STICKY_FLAGS_EN
    chk("stk_pre_c", 32'(sticky_carry), 32'd0);
    chk("stk_pre_o", 32'(sticky_ovf), 32'd1);
    sticky_clr = 1'b1;
    v = '{0, 8'h00, 0, 0, 0, 0, 0};
    run(v);
    sticky_clr = 1'b0;
    chk("stk_clr_c", 32'(sticky_carry), 32'd0);
    chk("stk_clr_o", 32'(sticky_ovf), 32'd0);
    v = '{1, 8'h00, 1, 1, 0, 0, 1};
    run(v);
    chk("stk_c_set", 32'(sticky_carry), 32'd1);
    chk("stk_o_clr", 32'(sticky_ovf), 32'd0);
    sticky_clr = 1'b1;
    v = '{1, 8'h80, 0, 0, 1, 0, 2};
    run(v);
    sticky_clr = 1'b0;
    chk("stk_clr_push_c", 32'(sticky_carry), 32'd0);
    chk("stk_clr_push_o", 32'(sticky_ovf), 32'd1);
    v = '{0, 8'h00, 0, 0, 0, 1, 1};
    run(v);
    v = '{0, 8'h00, 0, 0, 0, 1, 0};
    run(v);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
